// File: rtl/rope_access_arbiter.sv
// rope_access_arbiter
// Shares the fixed-memory (rope) flash between the AGC fixed-memory read path
// and the monitor/debug read port. One read is in flight at a time: IDLE
// arbitrates, ACCESS holds CE_n/OE_n low for READ_LATENCY cycles, and DONE
// presents the captured word with a one-cycle acknowledge to the winner.
// Out-of-range addresses skip the flash entirely and return zero.

module rope_access_arbiter #(
    parameter int unsigned READ_LATENCY   = 2,
    parameter logic [15:0] ROPE_WORDS     = 16'h4800,
    parameter int unsigned MAX_AGC_STREAK = 4
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        agc_req,
    input  logic [15:0] agc_addr,
    output logic        agc_ack,
    output logic [15:0] agc_data,
    input  logic        mon_req,
    input  logic [15:0] mon_addr,
    output logic        mon_ack,
    output logic [15:0] mon_data,
    output logic [14:0] mem_addr,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    input  logic [15:0] mem_data,
    output logic        busy,
    output logic        oor_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter reload: ACCESS lasts READ_LATENCY cycles, ending on cnt == 0.
    localparam logic [3:0] CNT_LOAD   = 4'(READ_LATENCY - 32'd1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_AGC_STREAK);

    // True when a word address lies inside the populated rope image.
    function automatic logic addr_in_range(input logic [15:0] addr);
        return (addr < ROPE_WORDS);
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [3:0]  streak_r, streak_s;
    logic        grant_mon_r, grant_mon_s;
    logic [14:0] mem_addr_r, mem_addr_s;
    logic        mem_ce_n_r, mem_oe_n_r;
    logic        mem_en_s;
    logic        agc_ack_r, agc_ack_s;
    logic        mon_ack_r, mon_ack_s;
    logic [15:0] agc_data_r, agc_data_s;
    logic [15:0] mon_data_r, mon_data_s;
    logic        oor_err_r, oor_err_s;
    logic        busy_r, busy_s;
    logic        win_mon_s;
    logic [15:0] win_addr_s;

    // Next-state, arbitration and next-output computation.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        streak_s    = streak_r;
        grant_mon_s = grant_mon_r;
        mem_addr_s  = mem_addr_r;
        mem_en_s    = 1'b0;
        agc_ack_s   = 1'b0;
        mon_ack_s   = 1'b0;
        oor_err_s   = 1'b0;
        agc_data_s  = agc_data_r;
        mon_data_s  = mon_data_r;
        win_mon_s   = 1'b0;
        win_addr_s  = agc_addr;

        case (state_r)
            ST_IDLE: begin
                if (agc_req || mon_req) begin
                    // AGC wins unless the monitor has waited through a full streak.
                    if (mon_req && (!agc_req || (streak_r == STREAK_MAX))) begin
                        win_mon_s  = 1'b1;
                        win_addr_s = mon_addr;
                        streak_s   = 4'd0;
                    end else begin
                        win_mon_s  = 1'b0;
                        win_addr_s = agc_addr;
                        if (mon_req) begin
                            if (streak_r < STREAK_MAX) begin
                                streak_s = streak_r + 4'd1;
                            end else begin
                                streak_s = streak_r;
                            end
                        end else begin
                            streak_s = 4'd0;
                        end
                    end
                    grant_mon_s = win_mon_s;

                    if (addr_in_range(win_addr_s)) begin
                        mem_addr_s = win_addr_s[14:0];
                        cnt_s      = CNT_LOAD;
                        mem_en_s   = 1'b1;
                        state_s    = ST_ACCESS;
                    end else begin
                        // Out of range: answer zero next cycle, flash untouched.
                        oor_err_s = 1'b1;
                        state_s   = ST_DONE;
                        if (win_mon_s) begin
                            mon_ack_s  = 1'b1;
                            mon_data_s = 16'h0000;
                        end else begin
                            agc_ack_s  = 1'b1;
                            agc_data_s = 16'h0000;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    // Last access cycle: capture the sensed word for the winner.
                    state_s = ST_DONE;
                    if (grant_mon_r) begin
                        mon_ack_s  = 1'b1;
                        mon_data_s = mem_data;
                    end else begin
                        agc_ack_s  = 1'b1;
                        agc_data_s = mem_data;
                    end
                end else begin
                    cnt_s    = cnt_r - 4'd1;
                    mem_en_s = 1'b1;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs; reset aborts any transaction immediately.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            streak_r    <= 4'd0;
            grant_mon_r <= 1'b0;
            mem_addr_r  <= 15'd0;
            mem_ce_n_r  <= 1'b1;
            mem_oe_n_r  <= 1'b1;
            agc_ack_r   <= 1'b0;
            mon_ack_r   <= 1'b0;
            agc_data_r  <= 16'h0000;
            mon_data_r  <= 16'h0000;
            oor_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            streak_r    <= streak_s;
            grant_mon_r <= grant_mon_s;
            mem_addr_r  <= mem_addr_s;
            mem_ce_n_r  <= ~mem_en_s;
            mem_oe_n_r  <= ~mem_en_s;
            agc_ack_r   <= agc_ack_s;
            mon_ack_r   <= mon_ack_s;
            agc_data_r  <= agc_data_s;
            mon_data_r  <= mon_data_s;
            oor_err_r   <= oor_err_s;
            busy_r      <= busy_s;
        end
    end

    assign agc_ack  = agc_ack_r;
    assign agc_data = agc_data_r;
    assign mon_ack  = mon_ack_r;
    assign mon_data = mon_data_r;
    assign mem_addr = mem_addr_r;
    assign mem_ce_n = mem_ce_n_r;
    assign mem_oe_n = mem_oe_n_r;
    assign busy     = busy_r;
    assign oor_err  = oor_err_r;

endmodule

// File: tb/tb_rope_access_arbiter.sv
// Self-checking bench for rope_access_arbiter: reset values, a table of single
// reads, hand-written multi-cycle sequences, and a randomized run checked
// against a transaction-timeline model of the arbiter.

module tb_rope_access_arbiter;

    localparam int          RL   = 2;
    localparam logic [15:0] ROPE = 16'h4800;
    localparam int          MAXS = 4;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b1;
    logic        agc_req = 1'b0;
    logic [15:0] agc_addr = 16'h0000;
    logic        agc_ack;
    logic [15:0] agc_data;
    logic        mon_req = 1'b0;
    logic [15:0] mon_addr = 16'h0000;
    logic        mon_ack;
    logic [15:0] mon_data;
    logic [14:0] mem_addr;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic [15:0] mem_data;
    logic        busy;
    logic        oor_err;

    logic [15:0] flash [0:32767];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    rope_access_arbiter #(
        .READ_LATENCY(RL), .ROPE_WORDS(ROPE), .MAX_AGC_STREAK(MAXS)
    ) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .agc_req(agc_req), .agc_addr(agc_addr), .agc_ack(agc_ack), .agc_data(agc_data),
        .mon_req(mon_req), .mon_addr(mon_addr), .mon_ack(mon_ack), .mon_data(mon_data),
        .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_data(mem_data),
        .busy(busy), .oor_err(oor_err)
    );

    // Flash model: drives the array word only while output-enabled.
    assign mem_data = mem_oe_n ? 16'hDEAD : flash[mem_addr];

    always #5 SIM_CLK = ~SIM_CLK;

    always @(posedge SIM_CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge SIM_CLK);
        agc_req = 1'b0;
        mon_req = 1'b0;
        SIM_RST = 1'b1;
        repeat (3) @(negedge SIM_CLK);
        SIM_RST = 1'b0;
    endtask

    typedef struct {
        bit          use_mon;
        logic [15:0] addr;
        logic [15:0] exp_data;
        bit          exp_oor;
        int          exp_lat;
    } vec_t;

    // One isolated read on one port; checks latency, data, flash activity.
    task automatic run_single(input vec_t v);
        int n, lat, en_cycles;
        bit got, addr_ok, en_match, other_ack;
        logic [15:0] other0, dat;
        logic oor;
        @(negedge SIM_CLK);
        other0 = v.use_mon ? agc_data : mon_data;
        if (v.use_mon) begin mon_req = 1'b1; mon_addr = v.addr; end
        else begin agc_req = 1'b1; agc_addr = v.addr; end
        n = cyc; got = 1'b0; lat = -1; en_cycles = 0; addr_ok = 1'b1;
        en_match = 1'b1; other_ack = 1'b0; dat = 16'h0000; oor = 1'b0;
        for (int w = 0; w < 24 && !got; w++) begin
            @(negedge SIM_CLK);
            if (mem_ce_n !== mem_oe_n) en_match = 1'b0;
            if (mem_ce_n === 1'b0) begin
                en_cycles++;
                if (mem_addr !== v.addr[14:0]) addr_ok = 1'b0;
            end
            if ((v.use_mon ? agc_ack : mon_ack) === 1'b1) other_ack = 1'b1;
            if ((v.use_mon ? mon_ack : agc_ack) === 1'b1) begin
                got = 1'b1;
                lat = cyc - n;
                dat = v.use_mon ? mon_data : agc_data;
                oor = oor_err;
                agc_req = 1'b0;
                mon_req = 1'b0;
            end
        end
        check("single_latency", 32'(lat), 32'(v.exp_lat));
        check("single_data", {16'h0, dat}, {16'h0, v.exp_data});
        check("single_oor", {31'h0, oor}, {31'h0, v.exp_oor});
        check("single_en_cycles", 32'(en_cycles), v.exp_oor ? 32'd0 : 32'(RL));
        check("single_mem_addr", {31'h0, addr_ok}, 32'd1);
        check("single_ce_oe_match", {31'h0, en_match}, 32'd1);
        check("single_other_ack", {31'h0, other_ack}, 32'd0);
        check("single_other_data", {16'h0, v.use_mon ? agc_data : mon_data}, {16'h0, other0});
        @(negedge SIM_CLK);
        check("single_ack_pulse", {30'h0, agc_ack, mon_ack}, 32'd0);
        check("single_busy_after", {31'h0, busy}, 32'd0);
    endtask

    function automatic logic [15:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 16'h47FF;
            1: return 16'h4800;
            2: return 16'($urandom_range(32'h4801, 32'hFFFF));
            default: return 16'($urandom_range(0, 32'h47FF));
        endcase
    endfunction

    // Randomized traffic against a timeline model: each grant fixes its own
    // enable window and ack cycle; outputs are compared every cycle.
    task automatic run_random(input int ncyc);
        int c, t_start, t_ack, streak;
        bit t_valid, t_mon, t_oor, win_mon, ack_now;
        logic [15:0] t_data, e_agc, e_mon, a;
        logic [14:0] e_addr;
        t_valid = 1'b0; t_mon = 1'b0; t_oor = 1'b0; t_start = 0; t_ack = 0;
        t_data = 16'h0; e_agc = 16'h0; e_mon = 16'h0; e_addr = 15'h0; streak = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge SIM_CLK);
            c = cyc;
            ack_now = t_valid && (c == t_ack);
            if (ack_now) begin
                if (t_mon) e_mon = t_data; else e_agc = t_data;
            end
            check("rnd_agc_ack", {31'h0, agc_ack}, {31'h0, ack_now && !t_mon});
            check("rnd_mon_ack", {31'h0, mon_ack}, {31'h0, ack_now && t_mon});
            check("rnd_oor_err", {31'h0, oor_err}, {31'h0, ack_now && t_oor});
            check("rnd_agc_data", {16'h0, agc_data}, {16'h0, e_agc});
            check("rnd_mon_data", {16'h0, mon_data}, {16'h0, e_mon});
            check("rnd_busy", {31'h0, busy}, {31'h0, t_valid && c > t_start && c <= t_ack});
            check("rnd_ce_n", {31'h0, mem_ce_n},
                  {31'h0, !(t_valid && !t_oor && c > t_start && c < t_ack)});
            check("rnd_oe_n", {31'h0, mem_oe_n},
                  {31'h0, !(t_valid && !t_oor && c > t_start && c < t_ack)});
            check("rnd_mem_addr", {17'h0, mem_addr}, {17'h0, e_addr});

            // Requester agents: hold until ack, then drop or re-request.
            if (agc_req && agc_ack) begin
                if ($urandom_range(0, 1) == 0) agc_addr = rnd_addr(); else agc_req = 1'b0;
            end else if (!agc_req && $urandom_range(0, 2) == 0) begin
                agc_req = 1'b1; agc_addr = rnd_addr();
            end
            if (mon_req && mon_ack) begin
                if ($urandom_range(0, 1) == 0) mon_addr = rnd_addr(); else mon_req = 1'b0;
            end else if (!mon_req && $urandom_range(0, 2) == 0) begin
                mon_req = 1'b1; mon_addr = rnd_addr();
            end

            // Arbiter is free from the cycle after the previous ack.
            if ((!t_valid || c > t_ack) && (agc_req || mon_req)) begin
                win_mon = mon_req && (!agc_req || streak == MAXS);
                if (win_mon) streak = 0;
                else if (mon_req) streak = (streak < MAXS) ? streak + 1 : streak;
                else streak = 0;
                a = win_mon ? mon_addr : agc_addr;
                t_oor = (a >= ROPE);
                t_mon = win_mon;
                t_start = c;
                t_ack = t_oor ? c + 1 : c + RL + 1;
                t_data = t_oor ? 16'h0000 : flash[a[14:0]];
                t_valid = 1'b1;
                if (!t_oor) e_addr = a[14:0];
            end
        end
        // Drain outstanding traffic before the next phase.
        @(negedge SIM_CLK);
        agc_req = 1'b0;
        mon_req = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        int n, a_cyc, m_cyc, acks, prev;
        logic [9:0] order, exp_order;
        logic [15:0] w;

        for (int i = 0; i < 32768; i++) flash[i] = 16'((i * 40503) ^ 32'h5A5A);
        flash[15'h0123] = 16'hA5A5;

        // Reset values.
        repeat (2) @(negedge SIM_CLK);
        check("rst_agc_ack", {31'h0, agc_ack}, 32'd0);
        check("rst_mon_ack", {31'h0, mon_ack}, 32'd0);
        check("rst_agc_data", {16'h0, agc_data}, 32'd0);
        check("rst_mon_data", {16'h0, mon_data}, 32'd0);
        check("rst_mem_addr", {17'h0, mem_addr}, 32'd0);
        check("rst_ce_n", {31'h0, mem_ce_n}, 32'd1);
        check("rst_oe_n", {31'h0, mem_oe_n}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_oor", {31'h0, oor_err}, 32'd0);
        SIM_RST = 1'b0;

        // Table of isolated reads.
        vecs[0] = '{1'b0, 16'h0123, 16'hA5A5, 1'b0, RL + 1};
        vecs[1] = '{1'b1, 16'h4800, 16'h0000, 1'b1, 1};
        vecs[2] = '{1'b1, 16'h47FF, flash[15'h47FF], 1'b0, RL + 1};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 1};
        vecs[4] = '{1'b0, 16'h0000, flash[15'h0000], 1'b0, RL + 1};
        vecs[5] = '{1'b1, 16'h8123, 16'h0000, 1'b1, 1};
        vecs[6] = '{1'b1, 16'h0123, 16'hA5A5, 1'b0, RL + 1};
        vecs[7] = '{1'b0, 16'h4800, 16'h0000, 1'b1, 1};
        for (int i = 0; i < 8; i++) run_single(vecs[i]);

        // Simultaneous requests: AGC first, monitor RL+2 cycles later.
        @(negedge SIM_CLK);
        agc_req = 1'b1; agc_addr = 16'h0010;
        mon_req = 1'b1; mon_addr = 16'h0020;
        n = cyc; a_cyc = -100; m_cyc = -1;
        for (int w2 = 0; w2 < 40 && (agc_req || mon_req); w2++) begin
            @(negedge SIM_CLK);
            if (agc_ack) begin
                a_cyc = cyc; agc_req = 1'b0;
                check("simul_agc_data", {16'h0, agc_data}, {16'h0, flash[15'h0010]});
            end
            if (mon_ack) begin
                m_cyc = cyc; mon_req = 1'b0;
                check("simul_mon_data", {16'h0, mon_data}, {16'h0, flash[15'h0020]});
            end
        end
        check("simul_agc_lat", 32'(a_cyc - n), 32'(RL + 1));
        check("simul_mon_gap", 32'(m_cyc - a_cyc), 32'(RL + 2));

        // Back-to-back held AGC request, addresses 0,1,2.
        @(negedge SIM_CLK);
        agc_req = 1'b1; agc_addr = 16'h0000;
        acks = 0; prev = -1;
        for (int w2 = 0; w2 < 60 && acks < 3; w2++) begin
            @(negedge SIM_CLK);
            if (agc_ack) begin
                check("b2b_data", {16'h0, agc_data}, {16'h0, flash[15'(acks)]});
                if (prev >= 0) check("b2b_gap", 32'(cyc - prev), 32'(RL + 2));
                prev = cyc;
                acks++;
                if (acks == 3) agc_req = 1'b0; else agc_addr = 16'(acks);
            end
        end
        check("b2b_count", 32'(acks), 32'd3);

        // Starvation guard with both requests held.
        do_reset();
        @(negedge SIM_CLK);
        agc_req = 1'b1; agc_addr = 16'h0100;
        mon_req = 1'b1; mon_addr = 16'h0200;
        acks = 0; order = 10'h0;
        for (int w2 = 0; w2 < 200 && acks < 10; w2++) begin
            @(negedge SIM_CLK);
            if (agc_ack) begin
                check("starve_agc_data", {16'h0, agc_data}, {16'h0, flash[agc_addr[14:0]]});
                order = {order[8:0], 1'b0}; acks++;
                agc_addr = agc_addr + 16'd1;
            end
            if (mon_ack) begin
                check("starve_mon_data", {16'h0, mon_data}, {16'h0, flash[mon_addr[14:0]]});
                order = {order[8:0], 1'b1}; acks++;
                mon_addr = mon_addr + 16'd1;
            end
        end
        agc_req = 1'b0; mon_req = 1'b0;
        exp_order = 10'h0;
        for (int i = 0; i < 10; i++) exp_order = {exp_order[8:0], (i % (MAXS + 1)) == MAXS};
        check("starve_order", {22'h0, order}, {22'h0, exp_order});
        check("starve_count", 32'(acks), 32'd10);

        // Reset in the first ACCESS cycle.
        repeat (RL + 3) @(negedge SIM_CLK);
        agc_req = 1'b1; agc_addr = 16'h0123;
        @(negedge SIM_CLK);
        check("rstmid_in_access", {31'h0, mem_ce_n}, 32'd0);
        #2 SIM_RST = 1'b1;
        #1;
        check("rstmid_ce_n", {31'h0, mem_ce_n}, 32'd1);
        check("rstmid_oe_n", {31'h0, mem_oe_n}, 32'd1);
        check("rstmid_busy", {31'h0, busy}, 32'd0);
        check("rstmid_mem_addr", {17'h0, mem_addr}, 32'd0);
        agc_req = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge SIM_CLK);
            if (agc_ack || mon_ack) acks++;
        end
        SIM_RST = 1'b0;
        repeat (RL + 3) begin
            @(negedge SIM_CLK);
            if (agc_ack || mon_ack) acks++;
        end
        check("rstmid_no_ack", 32'(acks), 32'd0);
        check("rstmid_agc_data", {16'h0, agc_data}, 32'd0);
        run_single(vecs[0]);

        // Randomized traffic from a clean reset.
        do_reset();
        run_random(3000);

        w = 16'h0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rope_access_arbiter.md
Name: rope_access_arbiter

Overview:
Sequences all read accesses to the fixed-memory (rope) flash and shares it between two requesters: the AGC fixed-memory read path and the monitor/debug read port. Drives the flash chip enables, holds the address for a configurable access time, captures the sensed word and returns it with a one-cycle acknowledge. Sits between the AGC core/monitor logic and the SST39VF200A flash model, replacing the direct hard-wired OE_n/address connection.

Parameters:
READ_LATENCY, 2, flash access cycles with CE_n/OE_n held low before the data is captured (1..15)
ROPE_WORDS, 16'h4800, first out-of-range word address; requests at or above this value return 0 with no flash access
MAX_AGC_STREAK, 4, consecutive AGC grants allowed while the monitor is waiting before the monitor is forced in (1..15)

Ports:
SIM_CLK  in  1  system clock; all state changes on the rising edge
SIM_RST  in  1  reset, asynchronous, active-high
agc_req  in  1  AGC read request; hold high with agc_addr stable until agc_ack
agc_addr  in  16  AGC word address
agc_ack  out  1  one-cycle pulse; agc_data valid in this cycle
agc_data  out  16  last word returned to AGC, held until the next agc_ack
mon_req  in  1  monitor read request, same rules as agc_req
mon_addr  in  16  monitor word address
mon_ack  out  1  one-cycle pulse; mon_data valid in this cycle
mon_data  out  16  last word returned to monitor, held until the next mon_ack
mem_addr  out  15  flash address (A14..A0; A15/A16 tied low outside the block)
mem_ce_n  out  1  flash chip enable, active low
mem_oe_n  out  1  flash output enable, active low
mem_data  in  16  flash DQ15..DQ0
busy  out  1  high whenever the FSM is not in IDLE
oor_err  out  1  one-cycle pulse in the ack cycle of an out-of-range request

Behaviour:
- Reset values: agc_ack=0, mon_ack=0, agc_data=0, mon_data=0, mem_addr=0, mem_ce_n=1, mem_oe_n=1, busy=0, oor_err=0, streak=0, state=IDLE.
- Reset asserted mid-transaction aborts it. No ack is issued, outputs return to their reset values immediately, and the FSM restarts in IDLE once reset deasserts.
- States:
  - IDLE: in cycle N, arbitrate among the sampled requests.
    - Winner's address ≥ ROPE_WORDS: go to DONE with captured word = 0 and the oor flag set; the flash is never enabled.
    - Otherwise: latch addr[14:0] into mem_addr and go to ACCESS with cnt = READ_LATENCY-1.
  - ACCESS: mem_ce_n=0, mem_oe_n=0, mem_addr stable. cnt decrements each cycle. On the cycle cnt==0, register mem_data and go to DONE.
  - DONE: pulse the granted port's ack (and oor_err if flagged). Update that port's data register. Deassert ce_n/oe_n. Return to IDLE.
- Latency, request sampled in IDLE at cycle N to ack:
  - In-range: cycle N+READ_LATENCY+1.
  - Out-of-range: cycle N+1.
- A req still high in the IDLE cycle after its ack is treated as a new request. Requesters drop req on the clock edge that samples ack if only one transfer is wanted.
- Minimum spacing between two in-range transfers is READ_LATENCY+2 cycles.
- Arbitration:
  - AGC has fixed priority.
  - streak counts consecutive AGC grants made while mon_req is high. It saturates at MAX_AGC_STREAK.
  - Both requesting and streak==MAX_AGC_STREAK: grant the monitor.
  - Any monitor grant, or an AGC grant with mon_req low, clears streak.
- Requests arriving while busy are not lost; they are sampled on the next IDLE.
- Address bits above bit 14 affect only the range check, never mem_addr.
- The data register of the non-granted port never changes.

Test Plan:
- Single in-range read, READ_LATENCY=2: agc_req at N, agc_addr=16'h0123, flash word 16'hA5A5 → mem_ce_n/oe_n low at N+1..N+2, mem_addr=15'h0123, agc_ack and agc_data=16'hA5A5 at N+3, mon_data unchanged.
- Out-of-range read: mon_req with mon_addr=16'h4800 → mon_ack, oor_err and mon_data=0 at N+1; mem_ce_n stays 1 throughout. Repeat with 16'h47FF → normal access, no oor_err.
- Simultaneous requests: agc_req and mon_req rise together → AGC served first, monitor granted in the IDLE following agc_ack, mon_ack exactly READ_LATENCY+2 cycles after agc_ack.
- Starvation guard, MAX_AGC_STREAK=4: agc_req and mon_req held high continuously → grant order AGC,AGC,AGC,AGC,MON,AGC,AGC,AGC,AGC,MON; each ack carries the correct port's word.
- Reset mid-ACCESS: assert SIM_RST asynchronously in the first ACCESS cycle → mem_ce_n/oe_n go to 1 without waiting for a clock edge, no ack is ever issued, busy=0. After release, a fresh agc_req completes normally with latency READ_LATENCY+1.
- Back-to-back held request: agc_req held high with agc_addr changed each ack (0,1,2) → acks spaced READ_LATENCY+2 cycles apart, data matches the flash contents at words 0,1,2.
